mac_tx_frame_feeder: RTL



---
 rtl/mac_tx_feeder_pkg.sv | 17 +
 rtl/mac_tx_frame_ram.sv | 21 ++
 rtl/mac_tx_frame_feeder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_tx_feeder_pkg.sv
// Shared types and sizing helpers for the MAC transmit frame feeder.
package mac_tx_feeder_pkg;

   typedef enum logic [1:0] {
      S_LOAD    = 2'd0,
      S_START   = 2'd1,
      S_SEND    = 2'd2,
      S_BACKOFF = 2'd3
   } state_t;

   localparam int RETRY_W = 4;

   function automatic int buf_aw(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/mac_tx_frame_ram.sv
// Frame buffer: one write port, one registered read port (block-RAM friendly).
module mac_tx_frame_ram #(
   parameter int P_DEPTH = 2048,
   parameter int P_AW    = 11
) (
   input  logic            tx_mac_clk,
   input  logic            wr_en,
   input  logic [P_AW-1:0] wr_addr,
   input  logic [7:0]      wr_data,
   input  logic [P_AW-1:0] rd_addr,
   output logic [7:0]      rd_data
);

   logic [7:0] mem [P_DEPTH];

   always_ff @(posedge tx_mac_clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/mac_tx_frame_feeder.sv
// Store-and-forward frame feeder for the MAC tx port.
// MAC_TX_RETRANSMIT_EN enables half-duplex retransmit/backoff handling.
//
// state     | meaning
// S_LOAD    | filling the buffer from the user stream (or discarding an oversize frame)
// S_START   | one prime cycle, then byte 0 presented until tx_rdy & tx_clk_en
// S_SEND    | byte rd_ptr presented, one byte consumed per tx_clk_en
// S_BACKOFF | waiting one tx_clk_en strobe before replaying from byte 0
module mac_tx_frame_feeder
   import mac_tx_feeder_pkg::*;
#(
   parameter int P_BUF_DEPTH = 2048,
   parameter int P_MAX_RETRY = 15
) (
   input  logic       tx_mac_clk,
   input  logic       reset,
   input  logic [7:0] s_data,
   input  logic       s_data_vld,
   input  logic       s_data_last,
   output logic       s_data_rdy,
   input  logic       tx_clk_en,
   output logic [7:0] tx_data,
   output logic       tx_data_en,
   input  logic       tx_rdy,
   input  logic       tx_retransmit,
   input  logic       tx_collision,
   output logic       tx_frame_done,
   output logic       tx_frame_drop,
   output logic       tx_busy
);

   localparam int AW = buf_aw(P_BUF_DEPTH);

   state_t        state, state_nxt;
   logic [AW-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt, rd_addr;
   logic [AW:0]   frame_len, frame_len_nxt;
   logic [7:0]    byte0, byte0_nxt, tx_data_nxt, ram_q;
   logic          primed, primed_nxt, ovf, ovf_nxt;
   logic          en_nxt, done_nxt, drop_nxt, wr_en;
   logic          in_tx, abort, consume, last_byte;

   assign s_data_rdy = (state == S_LOAD);
   assign in_tx      = (state == S_START) || (state == S_SEND);
   assign last_byte  = ({1'b0, rd_ptr} == frame_len - (AW+1)'(1));

`ifdef MAC_TX_RETRANSMIT_EN
   logic [RETRY_W-1:0] retry_cnt, retry_nxt;
   assign abort = in_tx && (tx_collision || tx_retransmit);
`else
   logic unused_rtx;
   assign unused_rtx = tx_retransmit ^ (P_MAX_RETRY != 0);
   assign abort      = in_tx && tx_collision;
`endif

   assign consume = tx_clk_en && !abort &&
                    ((state == S_SEND) || ((state == S_START) && primed && tx_rdy));

   // Read one byte ahead of tx_data so a consume can load the next byte immediately.
   assign rd_addr = rd_ptr + AW'(1) + AW'(consume);

   mac_tx_frame_ram #(
      .P_DEPTH (P_BUF_DEPTH),
      .P_AW    (AW)
   ) u_ram (
      .tx_mac_clk (tx_mac_clk),
      .wr_en      (wr_en),
      .wr_addr    (wr_ptr),
      .wr_data    (s_data),
      .rd_addr    (rd_addr),
      .rd_data    (ram_q)
   );

   always_comb begin
      state_nxt     = state;
      wr_ptr_nxt    = wr_ptr;
      rd_ptr_nxt    = rd_ptr;
      frame_len_nxt = frame_len;
      byte0_nxt     = byte0;
      tx_data_nxt   = tx_data;
      primed_nxt    = primed;
      ovf_nxt       = ovf;
      en_nxt        = tx_data_en;
      done_nxt      = 1'b0;
      drop_nxt      = 1'b0;
      wr_en         = 1'b0;
`ifdef MAC_TX_RETRANSMIT_EN
      retry_nxt     = retry_cnt;
`endif
      case (state)
         S_LOAD: begin
            if (s_data_vld) begin
               if (ovf) begin
                  if (s_data_last) begin
                     ovf_nxt    = 1'b0;
                     wr_ptr_nxt = '0;
                     drop_nxt   = 1'b1;
                  end
               end else begin
                  wr_en = 1'b1;
                  // Byte 0 is shadowed so START can present it without a RAM read.
                  if (wr_ptr == '0) byte0_nxt = s_data;
                  if (s_data_last) begin
                     frame_len_nxt = {1'b0, wr_ptr} + (AW+1)'(1);
                     rd_ptr_nxt    = '0;
                     primed_nxt    = 1'b0;
                     state_nxt     = S_START;
`ifdef MAC_TX_RETRANSMIT_EN
                     retry_nxt     = '0;
`endif
                  end else if (wr_ptr == AW'(P_BUF_DEPTH - 1)) begin
                     ovf_nxt = 1'b1;
                  end else begin
                     wr_ptr_nxt = wr_ptr + AW'(1);
                  end
               end
            end
         end
         S_START, S_SEND: begin
            if ((state == S_START) && !primed) begin
               primed_nxt  = 1'b1;
               en_nxt      = 1'b1;
               tx_data_nxt = byte0;
            end else if (consume) begin
               if (last_byte) begin
                  en_nxt    = 1'b0;
                  done_nxt  = 1'b1;
                  state_nxt = S_LOAD;
               end else begin
                  rd_ptr_nxt  = rd_ptr + AW'(1);
                  tx_data_nxt = ram_q;
                  state_nxt   = S_SEND;
               end
            end
         end
         S_BACKOFF: begin
            if (tx_clk_en) begin
               rd_ptr_nxt = '0;
               primed_nxt = 1'b0;
               state_nxt  = S_START;
            end
         end
         default: ;
      endcase

      if (abort) begin
         en_nxt = 1'b0;
`ifdef MAC_TX_RETRANSMIT_EN
         if (tx_retransmit && (retry_cnt < RETRY_W'(P_MAX_RETRY))) begin
            retry_nxt = retry_cnt + RETRY_W'(1);
            state_nxt = S_BACKOFF;
         end else begin
            drop_nxt  = 1'b1;
            state_nxt = S_LOAD;
         end
`else
         drop_nxt  = 1'b1;
         state_nxt = S_LOAD;
`endif
      end

      if ((state != S_LOAD) && (state_nxt == S_LOAD)) wr_ptr_nxt = '0;
   end

   always_ff @(posedge tx_mac_clk) begin
      if (reset) begin
         state         <= S_LOAD;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         frame_len     <= '0;
         byte0         <= '0;
         primed        <= 1'b0;
         ovf           <= 1'b0;
         tx_data       <= 8'h00;
         tx_data_en    <= 1'b0;
         tx_frame_done <= 1'b0;
         tx_frame_drop <= 1'b0;
         tx_busy       <= 1'b0;
      end else begin
         state         <= state_nxt;
         wr_ptr        <= wr_ptr_nxt;
         rd_ptr        <= rd_ptr_nxt;
         frame_len     <= frame_len_nxt;
         byte0         <= byte0_nxt;
         primed        <= primed_nxt;
         ovf           <= ovf_nxt;
         tx_data       <= tx_data_nxt;
         tx_data_en    <= en_nxt;
         tx_frame_done <= done_nxt;
         tx_frame_drop <= drop_nxt;
         tx_busy       <= (state_nxt != S_LOAD);
      end
   end

`ifdef MAC_TX_RETRANSMIT_EN
   always_ff @(posedge tx_mac_clk) begin
      if (reset) retry_cnt <= '0;
      else       retry_cnt <= retry_nxt;
   end
`endif

endmodule
